iu_muldiv_seq: RTL

IU_MULDIV_SEQ -- requirements
Module: iu_muldiv_seq

---
 rtl/iu_muldiv_seq_if.sv | 29 ++
 rtl/iu_muldiv_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iu_muldiv_seq_if.sv
// Request/response bundle for the sequential integer multiply/divide unit.
// The master modport is the issuing side, the slave modport is the unit itself.
interface iu_muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] y_out;
  logic             y_we;
  logic [3:0]       icc;
  logic             icc_we;
  logic             dz;

  modport master (
    output start, op, a, b, y_in,
    input  ready, done, result, y_out, y_we, icc, icc_we, dz
  );

  modport slave (
    input  start, op, a, b, y_in,
    output ready, done, result, y_out, y_we, icc, icc_we, dz
  );
endinterface

// File: rtl/iu_muldiv_seq.sv
// Sequential SPARC UMUL/SMUL/UDIV/SDIV (+cc) unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle. MULDIV_DIVZERO_TRAP_EN enables the divide-by-zero trap.
module iu_muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic              clk,
  input logic              rst_n,
  iu_muldiv_seq_if.slave   bus
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, dvs, y_hold;
  logic             is_div, is_sgn, is_cc, neg, ovf, bad, trap;

  logic             ready_r, done_r, y_we_r, icc_we_r, dz_r;
  logic [WIDTH-1:0] result_r, y_out_r;
  logic [3:0]       icc_r;

  // Decode and operand conditioning, consumed only at the accept edge.
  logic               d_valid, d_div, d_sgn, d_cc, d_neg, d_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] dvd_mag;

  always_comb begin
    d_cc    = bus.op[4];
    d_sgn   = bus.op[0];
    d_div   = bus.op[2];
    d_valid = !bus.op[5] && ((bus.op[3:1] == 3'b101) || (bus.op[3:1] == 3'b111));
    a_mag   = (d_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag   = (d_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    dvd_mag = (d_sgn && bus.y_in[WIDTH-1]) ? -{bus.y_in, bus.a} : {bus.y_in, bus.a};
    d_neg   = d_sgn && ((d_div ? bus.y_in[WIDTH-1] : bus.a[WIDTH-1]) ^ bus.b[WIDTH-1]);
    // Quotient needs more than WIDTH bits exactly when the high word reaches the divisor.
    d_ovf   = dvd_mag[2*WIDTH-1:WIDTH] >= b_mag;
  end

  // One iteration of either algorithm; hi:lo is the shared product/remainder:quotient pair.
  logic [WIDTH:0] sum, rem, diff;
  logic           ge;

  always_comb begin
    sum  = {1'b0, hi} + {1'b0, dvs};
    rem  = {hi, lo[WIDTH-1]};
    ge   = rem >= {1'b0, dvs};
    diff = rem - {1'b0, dvs};
  end

  // Sign correction and saturation applied in FIX.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   f_res, f_y;
  logic               f_v;

  always_comb begin
    prod  = neg ? -{hi, lo} : {hi, lo};
    f_res = lo;
    f_y   = y_hold;
    f_v   = 1'b0;
    if (!is_div) begin
      f_res = prod[WIDTH-1:0];
      f_y   = prod[2*WIDTH-1:WIDTH];
    end else if (!is_sgn) begin
      if (ovf) begin
        f_res = '1;
        f_v   = 1'b1;
      end
    end else if (neg) begin
      if (ovf || (lo[WIDTH-1] && |lo[WIDTH-2:0])) begin
        f_res = SMIN;
        f_v   = 1'b1;
      end else begin
        f_res = -lo;
      end
    end else if (ovf || lo[WIDTH-1]) begin
      f_res = SMAX;
      f_v   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      y_hold   <= '0;
      is_div   <= 1'b0;
      is_sgn   <= 1'b0;
      is_cc    <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      bad      <= 1'b0;
      trap     <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      result_r <= '0;
      y_out_r  <= '0;
      icc_r    <= '0;
      y_we_r   <= 1'b0;
      icc_we_r <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      y_we_r   <= 1'b0;
      icc_we_r <= 1'b0;
      dz_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ready_r <= 1'b0;
            cnt     <= '0;
            is_div  <= d_div;
            is_sgn  <= d_sgn;
            is_cc   <= d_cc;
            neg     <= d_neg;
            ovf     <= d_ovf;
            bad     <= !d_valid;
            trap    <= 1'b0;
            y_hold  <= bus.y_in;
            dvs     <= b_mag;
            if (d_div) begin
              hi <= dvd_mag[2*WIDTH-1:WIDTH];
              lo <= dvd_mag[WIDTH-1:0];
            end else begin
              hi <= '0;
              lo <= a_mag;
            end
            state <= d_valid ? RUN : FIX;
`ifdef MULDIV_DIVZERO_TRAP_EN
            if (d_valid && d_div && (bus.b == '0)) begin
              trap  <= 1'b1;
              state <= FIX;
            end
`endif
          end
        end
        RUN: begin
          if (!is_div) begin
            if (lo[0]) begin
              hi <= sum[WIDTH:1];
              lo <= {sum[0], lo[WIDTH-1:1]};
            end else begin
              hi <= {1'b0, hi[WIDTH-1:1]};
              lo <= {hi[0], lo[WIDTH-1:1]};
            end
          end else if (ge) begin
            hi <= diff[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= rem[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          done_r  <= 1'b1;
          if (bad) begin
            result_r <= '0;
          end else if (trap) begin
            dz_r <= 1'b1;
          end else begin
            result_r <= f_res;
            y_out_r  <= f_y;
            y_we_r   <= !is_div;
            icc_we_r <= is_cc;
            if (is_cc) icc_r <= {f_res[WIDTH-1], f_res == '0, f_v, 1'b0};
          end
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.y_out  = y_out_r;
  assign bus.icc    = icc_r;
  assign bus.y_we   = y_we_r;
  assign bus.icc_we = icc_we_r;
  assign bus.dz     = dz_r;

endmodule
